// File: rtl/mem.sv
`default_nettype none
// ============================================================================
//  Module   : mem
//  Purpose  : Memory-access pipeline stage between EX and WB. Holds one
//             instruction, performs at most one data-memory load/store over a
//             req/ack port, aligns and extends load data and registers the
//             WB bus. EX is stalled while an access is outstanding.
//  Revision : 1.0  initial release
// ============================================================================
module mem (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ex_valid_i,
  input  logic [106:0]  ex2mem_bus_ri,
  output logic          mem_allowin_o,
  output logic          dm_req_o,
  output logic          dm_we_o,
  output logic [31:0]   dm_addr_o,
  output logic [3:0]    dm_wstrb_o,
  output logic [31:0]   dm_wdata_o,
  input  logic [31:0]   dm_rdata_i,
  input  logic          dm_ack_i,
  output logic          mem_valid_o,
  output logic [69:0]   mem2wb_bus_ro,
  output logic [4:0]    mem_wdest_o,
  output logic          misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [106:0]  inst_q, inst_d;
  logic [69:0]   out_bus_q, out_bus_d;
  logic          out_valid_q, out_valid_d;
  logic          misalign_q, misalign_d;

  // Fields of the held instruction
  logic [2:0]  ls_type;
  logic        is_load, is_store, wen;
  logic [31:0] store_data, alu_result, pc;
  logic [4:0]  wdest;

  assign ls_type    = inst_q[106:104];
  assign is_load    = inst_q[103];
  assign is_store   = inst_q[102];
  assign store_data = inst_q[101:70];
  assign wdest      = inst_q[69:65];
  assign wen        = inst_q[64];
  assign alu_result = inst_q[63:32];
  assign pc         = inst_q[31:0];

  logic        busy, mem_op, misaligned, finish, capture;
  logic [31:0] byte_shift;
  logic [15:0] half_sel;
  logic [31:0] load_val, result;

  // Access classification, handshake and stall control
  always_comb begin
    busy       = (state_q == S_RUN) || (state_q == S_WAIT);
    mem_op     = is_load || is_store;
    misaligned = busy && mem_op &&
                 (((ls_type[1:0] == 2'b01) && alu_result[0]) ||
                  ((ls_type[1:0] == 2'b10) && (alu_result[1:0] != 2'b00)));
    finish     = 1'b0;
    if (state_q == S_RUN)
      finish = !mem_op || misaligned || dm_ack_i;
    else if (state_q == S_WAIT)
      finish = dm_ack_i;
    mem_allowin_o = (state_q == S_IDLE) || finish;
    capture       = ex_valid_i && mem_allowin_o;
    dm_req_o      = busy && mem_op && !misaligned;
    mem_wdest_o   = (busy && wen) ? wdest : 5'd0;
  end

  // Request address, store strobes and lane-replicated store data
  always_comb begin
    dm_we_o    = is_store;
    dm_addr_o  = {alu_result[31:2], 2'b00};
    dm_wstrb_o = 4'b0000;
    dm_wdata_o = 32'd0;
    if (is_store) begin
      case (ls_type[1:0])
        2'b00: begin
          dm_wstrb_o = 4'b0001 << alu_result[1:0];
          dm_wdata_o = {4{store_data[7:0]}};
        end
        2'b01: begin
          dm_wstrb_o = alu_result[1] ? 4'b1100 : 4'b0011;
          dm_wdata_o = {2{store_data[15:0]}};
        end
        default: begin
          dm_wstrb_o = 4'b1111;
          dm_wdata_o = store_data;
        end
      endcase
    end
  end

  // Load lane selection and sign/zero extension; ls_type[2] selects unsigned
  always_comb begin
    byte_shift = dm_rdata_i >> {alu_result[1:0], 3'b000};
    half_sel   = alu_result[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    case (ls_type[1:0])
      2'b00:   load_val = ls_type[2] ? {24'd0, byte_shift[7:0]}
                                     : {{24{byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   load_val = ls_type[2] ? {16'd0, half_sel}
                                     : {{16{half_sel[15]}}, half_sel};
      default: load_val = dm_rdata_i;
    endcase
    // A dropped misaligned load never read memory, so forward the address
    // instead of undefined read data.
    result = (is_load && !misaligned) ? load_val : alu_result;
  end

  // Next-state, instruction capture and output register loading
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    out_bus_d   = out_bus_q;
    out_valid_d = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = capture ? S_RUN : S_IDLE;
      S_RUN,
      S_WAIT:  state_d = finish ? (capture ? S_RUN : S_IDLE) : S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (capture)
      inst_d = ex2mem_bus_ri;
    if (finish) begin
      out_bus_d   = {wdest, wen && !misaligned, result, pc};
      out_valid_d = 1'b1;
      misalign_d  = misaligned;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      inst_q      <= '0;
      out_bus_q   <= '0;
      out_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      out_bus_q   <= out_bus_d;
      out_valid_q <= out_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_valid_o   = out_valid_q;
  assign mem2wb_bus_ro = out_bus_q;
  assign misalign_o    = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem
//  Purpose  : Directed self-checking bench for the mem pipeline stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         ex_valid_i;
  logic [106:0] ex2mem_bus_ri;
  logic         mem_allowin_o;
  logic         dm_req_o, dm_we_o;
  logic [31:0]  dm_addr_o;
  logic [3:0]   dm_wstrb_o;
  logic [31:0]  dm_wdata_o;
  logic [31:0]  dm_rdata_i;
  logic         dm_ack_i;
  logic         mem_valid_o;
  logic [69:0]  mem2wb_bus_ro;
  logic [4:0]   mem_wdest_o;
  logic         misalign_o;

  int checks = 0;
  int errors = 0;

  mem dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ex_valid_i    (ex_valid_i),
    .ex2mem_bus_ri (ex2mem_bus_ri),
    .mem_allowin_o (mem_allowin_o),
    .dm_req_o      (dm_req_o),
    .dm_we_o       (dm_we_o),
    .dm_addr_o     (dm_addr_o),
    .dm_wstrb_o    (dm_wstrb_o),
    .dm_wdata_o    (dm_wdata_o),
    .dm_rdata_i    (dm_rdata_i),
    .dm_ack_i      (dm_ack_i),
    .mem_valid_o   (mem_valid_o),
    .mem2wb_bus_ro (mem2wb_bus_ro),
    .mem_wdest_o   (mem_wdest_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [106:0] mk(input logic [2:0] lt, input logic ld, input logic st,
                                      input logic [31:0] sd, input logic [4:0] wd,
                                      input logic we, input logic [31:0] alu,
                                      input logic [31:0] pc);
    mk = {lt, ld, st, sd, wd, we, alu, pc};
  endfunction

  function automatic logic [69:0] wb(input logic [4:0] wd, input logic we,
                                     input logic [31:0] res, input logic [31:0] pc);
    wb = {wd, we, res, pc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [106:0] b);
    ex_valid_i    = 1'b1;
    ex2mem_bus_ri = b;
    step();
    ex_valid_i    = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; ex_valid_i = 1'b0; ex2mem_bus_ri = '0;
    dm_rdata_i = 32'd0; dm_ack_i = 1'b0;
    step(); step();
    chk("rst_valid",   mem_valid_o, 0);
    chk("rst_bus",     mem2wb_bus_ro, 0);
    chk("rst_misal",   misalign_o, 0);
    chk("rst_req",     dm_req_o, 0);
    chk("rst_allowin", mem_allowin_o, 1);
    chk("rst_wdest",   mem_wdest_o, 0);
    rst_i = 1'b1;
    step();

    // ADD: non-memory op, one valid pulse, no request
    issue(mk(3'b000, 0, 0, 32'd0, 5'd3, 1, 32'h5, 32'h1C00_0000));
    #1;
    chk("add_req",     dm_req_o, 0);
    chk("add_wdest",   mem_wdest_o, 3);
    chk("add_allowin", mem_allowin_o, 1);
    step();
    chk("add_valid",   mem_valid_o, 1);
    chk("add_bus",     mem2wb_bus_ro, wb(5'd3, 1, 32'h5, 32'h1C00_0000));
    chk("add_misal",   misalign_o, 0);
    step();
    chk("add_pulse",   mem_valid_o, 0);

    // LB at 0x1003 with zero-wait ack
    issue(mk(3'b000, 1, 0, 32'd0, 5'd5, 1, 32'h1003, 32'h100));
    dm_ack_i = 1'b1; dm_rdata_i = 32'h80FF_1234;
    #1;
    chk("lb_req",   dm_req_o, 1);
    chk("lb_we",    dm_we_o, 0);
    chk("lb_addr",  dm_addr_o, 32'h1000);
    chk("lb_wstrb", dm_wstrb_o, 0);
    step();
    dm_ack_i = 1'b0;
    chk("lb_valid", mem_valid_o, 1);
    chk("lb_bus",   mem2wb_bus_ro, wb(5'd5, 1, 32'hFFFF_FF80, 32'h100));

    // LBU at the same address and data
    issue(mk(3'b100, 1, 0, 32'd0, 5'd6, 1, 32'h1003, 32'h104));
    dm_ack_i = 1'b1;
    step();
    dm_ack_i = 1'b0;
    chk("lbu_bus",  mem2wb_bus_ro, wb(5'd6, 1, 32'h0000_0080, 32'h104));

    // LH at 0x7002: upper halfword, sign-extended
    issue(mk(3'b001, 1, 0, 32'd0, 5'd8, 1, 32'h7002, 32'h108));
    dm_ack_i = 1'b1; dm_rdata_i = 32'h8001_1234;
    step();
    dm_ack_i = 1'b0;
    chk("lh_bus",   mem2wb_bus_ro, wb(5'd8, 1, 32'hFFFF_8001, 32'h108));

    // SB at 0x6001: byte replicated, strobe on lane 1
    issue(mk(3'b000, 0, 1, 32'h1234_565A, 5'd0, 0, 32'h6001, 32'h10C));
    dm_ack_i = 1'b1;
    #1;
    chk("sb_we",    dm_we_o, 1);
    chk("sb_wstrb", dm_wstrb_o, 4'b0010);
    chk("sb_wdata", dm_wdata_o, 32'h5A5A_5A5A);
    step();
    dm_ack_i = 1'b0;
    chk("sb_bus",   mem2wb_bus_ro, wb(5'd0, 0, 32'h6001, 32'h10C));
    step();

    // SH at 0x2002, ack after 3 wait cycles
    issue(mk(3'b001, 0, 1, 32'h0000_ABCD, 5'd0, 0, 32'h2002, 32'h200));
    for (int i = 0; i < 4; i++) begin
      dm_ack_i = (i == 3);
      #1;
      chk("sh_req",     dm_req_o, 1);
      chk("sh_wstrb",   dm_wstrb_o, 4'b1100);
      chk("sh_wdata",   dm_wdata_o, 32'hABCD_ABCD);
      chk("sh_addr",    dm_addr_o, 32'h2000);
      chk("sh_allowin", mem_allowin_o, (i == 3));
      chk("sh_novalid", mem_valid_o, 0);
      step();
    end
    dm_ack_i = 1'b0;
    chk("sh_valid", mem_valid_o, 1);
    chk("sh_bus",   mem2wb_bus_ro, wb(5'd0, 0, 32'h2002, 32'h200));
    step();
    chk("sh_pulse", mem_valid_o, 0);

    // Misaligned LW at 0x3001
    issue(mk(3'b010, 1, 0, 32'd0, 5'd7, 1, 32'h3001, 32'h300));
    #1;
    chk("mis_req",     dm_req_o, 0);
    chk("mis_allowin", mem_allowin_o, 1);
    step();
    chk("mis_valid",   mem_valid_o, 1);
    chk("mis_pulse",   misalign_o, 1);
    chk("mis_bus",     mem2wb_bus_ro, wb(5'd7, 0, 32'h3001, 32'h300));
    step();
    chk("mis_end",     misalign_o, 0);
    chk("mis_vend",    mem_valid_o, 0);

    // Three back-to-back LWs with immediate acks
    ex_valid_i = 1'b1; ex2mem_bus_ri = mk(3'b010, 1, 0, 0, 5'd1, 1, 32'h4000, 32'h400);
    step();
    ex2mem_bus_ri = mk(3'b010, 1, 0, 0, 5'd2, 1, 32'h4004, 32'h404);
    dm_ack_i = 1'b1; dm_rdata_i = 32'h1111_1111;
    #1;
    chk("b2b_addr0",   dm_addr_o, 32'h4000);
    chk("b2b_allow0",  mem_allowin_o, 1);
    step();
    chk("b2b_valid0",  mem_valid_o, 1);
    chk("b2b_bus0",    mem2wb_bus_ro, wb(5'd1, 1, 32'h1111_1111, 32'h400));
    ex2mem_bus_ri = mk(3'b010, 1, 0, 0, 5'd3, 1, 32'h4008, 32'h408);
    dm_rdata_i = 32'h2222_2222;
    #1;
    chk("b2b_addr1",   dm_addr_o, 32'h4004);
    step();
    chk("b2b_valid1",  mem_valid_o, 1);
    chk("b2b_bus1",    mem2wb_bus_ro, wb(5'd2, 1, 32'h2222_2222, 32'h404));
    ex_valid_i = 1'b0; dm_rdata_i = 32'h3333_3333;
    step();
    chk("b2b_valid2",  mem_valid_o, 1);
    chk("b2b_bus2",    mem2wb_bus_ro, wb(5'd3, 1, 32'h3333_3333, 32'h408));
    dm_ack_i = 1'b0;
    step();
    chk("b2b_end",     mem_valid_o, 0);

    // Reset during WAIT, then a late ack
    issue(mk(3'b010, 1, 0, 32'd0, 5'd4, 1, 32'h5000, 32'h500));
    step();
    chk("rw_req",      dm_req_o, 1);
    chk("rw_allowin",  mem_allowin_o, 0);
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    chk("rw_req0",     dm_req_o, 0);
    chk("rw_allow1",   mem_allowin_o, 1);
    chk("rw_wdest",    mem_wdest_o, 0);
    chk("rw_bus",      mem2wb_bus_ro, 0);
    dm_ack_i = 1'b1;
    step();
    chk("rw_novalid",  mem_valid_o, 0);
    chk("rw_noreq",    dm_req_o, 0);
    dm_ack_i = 1'b0;
    step();
    chk("rw_idle",     mem_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
